pc_fetch_unit: RTL and testbench

- Instruction-fetch stage of the single-cycle MIPS core. It owns the 32-bit PC and drives the instruction ROM word address; the ROM returns the instruction combinationally in the same cycle.
- Computes next-PC for sequential, branch, J/JAL and JR/JALR flow.
- Enters the interrupt vector (timer IRQ) and the exception vector (undefined opcode).
- Produces the EPC value written to $k0 ($26). PC[31] is the kernel/supervisor bit.

---
 rtl/pc_fetch_unit_if.sv | 27 ++
 rtl/pc_fetch_unit.sv | 84 ++++++++
 tb/tb_pc_fetch_unit.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/pc_fetch_unit_if.sv
// rtl/pc_fetch_unit_if.sv - fetch stage signal bundle between core/decoder and the PC unit
interface pc_fetch_unit_if;
    logic [31:0] instr;
    logic [1:0]  pc_sel;
    logic        branch_taken;
    logic [31:0] jr_target;
    logic        undef_op;
    logic        irq;
    logic [30:0] rom_addr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        instr_valid;
    logic        epc_we;
    logic [31:0] epc_value;
    logic        in_kernel;
    logic [31:0] instret;

    modport master (
        output instr, pc_sel, branch_taken, jr_target, undef_op, irq,
        input  rom_addr, pc, pc_plus4, instr_valid, epc_we, epc_value, in_kernel, instret
    );

    modport slave (
        input  instr, pc_sel, branch_taken, jr_target, undef_op, irq,
        output rom_addr, pc, pc_plus4, instr_valid, epc_we, epc_value, in_kernel, instret
    );
endinterface

// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - PC register, next-PC selection, IRQ/exception vectoring and retire counter
module pc_fetch_unit #(
    parameter logic [31:0] RESET_VEC = 32'h8000_0000,
    parameter logic [31:0] IRQ_VEC   = 32'h8000_0004,
    parameter logic [31:0] EXC_VEC   = 32'h8000_0008
) (
    input  logic              clk,
    input  logic              reset,
    pc_fetch_unit_if.slave    bus
);
    logic [31:0] pc_q, pc_d;
    logic        irq_d_q, irq_d_d;
    logic        irq_pending_q, irq_pending_d;
    logic [31:0] instret_q, instret_d;

    logic [30:0] seq_low;
    logic [30:0] br_off;
    logic [31:0] flow_pc;
    logic        irq_take;
    logic        instr_valid;

    // Offset is the sign-extended word displacement truncated to the 31-bit address space.
    assign seq_low  = pc_q[30:0] + 31'd4;
    assign br_off   = {{13{bus.instr[15]}}, bus.instr[15:0], 2'b00};
    assign irq_take = irq_pending_q & ~pc_q[31] & ~bus.undef_op & ~reset;

    always_comb begin
        flow_pc = {pc_q[31], seq_low};
        unique case (bus.pc_sel)
            2'b00: flow_pc = {pc_q[31], seq_low};
            2'b01: flow_pc = bus.branch_taken ? {pc_q[31], seq_low + br_off} : {pc_q[31], seq_low};
            2'b10: flow_pc = {pc_q[31], seq_low[30:28], bus.instr[25:0], 2'b00};
            2'b11: flow_pc = bus.jr_target;
        endcase
    end

    always_comb begin
        pc_d          = flow_pc;
        instr_valid   = ~reset;
        bus.epc_we    = 1'b0;
        bus.epc_value = 32'h0;
        if (reset) begin
            pc_d = RESET_VEC;
        end else if (bus.undef_op) begin
            pc_d          = EXC_VEC;
            instr_valid   = 1'b0;
            bus.epc_we    = 1'b1;
            bus.epc_value = {pc_q[31], seq_low};
        end else if (irq_take) begin
            pc_d          = IRQ_VEC;
            instr_valid   = 1'b0;
            bus.epc_we    = 1'b1;
            bus.epc_value = pc_q;
        end
    end

    // A new rising edge of irq wins over a coincident take.
    always_comb begin
        irq_d_d       = bus.irq;
        irq_pending_d = (bus.irq & ~irq_d_q) | (irq_pending_q & ~irq_take);
        instret_d     = instr_valid ? instret_q + 32'd1 : instret_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q          <= RESET_VEC;
            irq_d_q       <= 1'b0;
            irq_pending_q <= 1'b0;
            instret_q     <= 32'h0;
        end else begin
            pc_q          <= pc_d;
            irq_d_q       <= irq_d_d;
            irq_pending_q <= irq_pending_d;
            instret_q     <= instret_d;
        end
    end

    assign bus.rom_addr    = pc_q[30:0];
    assign bus.pc          = pc_q;
    assign bus.pc_plus4    = {pc_q[31], seq_low};
    assign bus.in_kernel   = pc_q[31];
    assign bus.instret     = instret_q;
    assign bus.instr_valid = instr_valid;
endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb/tb_pc_fetch_unit.sv - directed self-checking bench for pc_fetch_unit
module tb_pc_fetch_unit;
    logic clk;
    logic reset;
    int   checks;
    int   errors;

    pc_fetch_unit_if bus ();

    pc_fetch_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b1;
        bus.instr = 32'h0;
        bus.pc_sel = 2'b00;
        bus.branch_taken = 1'b0;
        bus.jr_target = 32'h0;
        bus.undef_op = 1'b0;
        bus.irq = 1'b0;
        #12;
        chk("rst_pc", bus.pc, 32'h8000_0000);
        chk("rst_valid", {31'h0, bus.instr_valid}, 32'h0);
        chk("rst_epc_we", {31'h0, bus.epc_we}, 32'h0);
        chk("rst_epc_value", bus.epc_value, 32'h0);
        chk("rst_instret", bus.instret, 32'h0);

        bus.instr = 32'h0800_0003;
        bus.pc_sel = 2'b10;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("first_rom_addr", {1'b0, bus.rom_addr}, 32'h0);
        chk("first_valid", {31'h0, bus.instr_valid}, 32'h1);
        step();
        chk("jump_pc", bus.pc, 32'h8000_000C);
        chk("jump_rom_addr", {1'b0, bus.rom_addr}, 32'h0000_000C);
        chk("jump_instret", bus.instret, 32'd1);

        bus.pc_sel = 2'b11;
        bus.jr_target = 32'h0000_0040;
        step();
        chk("jr_pc", bus.pc, 32'h0000_0040);
        chk("jr_user", {31'h0, bus.in_kernel}, 32'h0);

        bus.pc_sel = 2'b01;
        bus.branch_taken = 1'b1;
        bus.instr = 32'h0000_FFFD;
        step();
        chk("br_taken_pc", bus.pc, 32'h0000_0038);

        bus.pc_sel = 2'b11;
        bus.jr_target = 32'h0000_0040;
        step();
        bus.pc_sel = 2'b01;
        bus.branch_taken = 1'b0;
        step();
        chk("br_not_taken_pc", bus.pc, 32'h0000_0044);
        chk("pc_plus4", bus.pc_plus4, 32'h0000_0048);

        bus.pc_sel = 2'b11;
        bus.jr_target = 32'h0000_004C;
        step();
        bus.pc_sel = 2'b00;
        bus.irq = 1'b1;
        step();
        bus.irq = 1'b0;
        #1;
        chk("irq_pc", bus.pc, 32'h0000_0050);
        chk("irq_valid", {31'h0, bus.instr_valid}, 32'h0);
        chk("irq_epc_we", {31'h0, bus.epc_we}, 32'h1);
        chk("irq_epc_value", bus.epc_value, 32'h0000_0050);
        chk("irq_instret_before", bus.instret, 32'd7);
        step();
        chk("irq_vec_pc", bus.pc, 32'h8000_0004);
        chk("irq_instret_after", bus.instret, 32'd7);

        bus.pc_sel = 2'b11;
        bus.jr_target = 32'h8000_00B4;
        step();
        chk("kern_pc", bus.pc, 32'h8000_00B4);
        bus.pc_sel = 2'b00;
        bus.irq = 1'b1;
        step();
        bus.irq = 1'b0;
        #1;
        chk("kern_hold_pc", bus.pc, 32'h8000_00B8);
        chk("kern_hold_valid", {31'h0, bus.instr_valid}, 32'h1);
        chk("kern_hold_epc_we", {31'h0, bus.epc_we}, 32'h0);
        bus.pc_sel = 2'b11;
        bus.jr_target = 32'h0000_0050;
        step();
        bus.pc_sel = 2'b00;
        #1;
        chk("ret_pc", bus.pc, 32'h0000_0050);
        chk("ret_irq_valid", {31'h0, bus.instr_valid}, 32'h0);
        chk("ret_irq_epc", bus.epc_value, 32'h0000_0050);
        step();
        chk("ret_irq_vec", bus.pc, 32'h8000_0004);

        bus.pc_sel = 2'b11;
        bus.jr_target = 32'h0000_0060;
        bus.irq = 1'b1;
        step();
        bus.irq = 1'b0;
        bus.undef_op = 1'b1;
        #1;
        chk("undef_pc", bus.pc, 32'h0000_0060);
        chk("undef_valid", {31'h0, bus.instr_valid}, 32'h0);
        chk("undef_epc_we", {31'h0, bus.epc_we}, 32'h1);
        chk("undef_epc_value", bus.epc_value, 32'h0000_0064);
        step();
        bus.undef_op = 1'b0;
        #1;
        chk("undef_vec", bus.pc, 32'h8000_0008);
        bus.jr_target = 32'h0000_0070;
        step();
        chk("pending_kept_pc", bus.pc, 32'h0000_0070);
        chk("pending_kept_valid", {31'h0, bus.instr_valid}, 32'h0);
        chk("pending_kept_epc", bus.epc_value, 32'h0000_0070);
        bus.pc_sel = 2'b00;
        step();
        chk("pending_vec", bus.pc, 32'h8000_0004);

        bus.pc_sel = 2'b11;
        bus.jr_target = 32'h8000_0120;
        step();
        chk("pre_reset_pc", bus.pc, 32'h8000_0120);
        #2;
        reset = 1'b1;
        #1;
        chk("async_rst_pc", bus.pc, 32'h8000_0000);
        chk("async_rst_instret", bus.instret, 32'h0);
        chk("async_rst_valid", {31'h0, bus.instr_valid}, 32'h0);
        chk("async_rst_epc_we", {31'h0, bus.epc_we}, 32'h0);
        @(negedge clk);
        bus.pc_sel = 2'b00;
        reset = 1'b0;
        step();
        chk("post_rst_seq", bus.pc, 32'h8000_0004);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
